instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Registered, parametrised successor to the combinational field splitter: accepts raw
//  32-bit RV instructions plus PC over a valid/ready handshake, decodes fields, selects the one
//  immediate for the opcode, flags illegal encodings, and buffers results in a DEPTH-entry FIFO.
//  Sits between fetch and the register-read/execute stage. Supports RV32I and RV64I immediates.
// PARAMETERS
//  XLEN   32  datapath width; 32 or 64 (PC and immediate width, shamt width 5 or 6)
//  DEPTH  2   decoded-entry FIFO depth; power of two, >=2
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  flush         in   1     discard all buffered entries (synchronous)
//  in_valid      in   1     in_instr/in_pc valid
//  in_ready      out  1     stage can accept; = (count < DEPTH), registered-state only
//  in_instr      in   32    raw instruction word
//  in_pc         in   XLEN  PC of in_instr
//  out_valid     out  1     head entry valid; = (count != 0)
//  out_ready     in   1     consumer accepts head entry
//  out_pc        out  XLEN  PC of head entry
//  out_opcode    out  7     instr[6:0]
//  out_rd/rs1/rs2 out 5 each  instr[11:7]/[19:15]/[24:20]
//  out_funct3    out  3     instr[14:12]
//  out_funct7    out  7     instr[31:25]
//  out_imm       out  XLEN  selected, sign-extended immediate
//  out_imm_type  out  3     0 NONE,1 I,2 S,3 B,4 U,5 J,6 SHAMT
//  out_illegal   out  1     encoding not recognised
// BEHAVIOUR
//  - Reset (async): count=0, rd/wr ptr=0; out_valid=0, in_ready=1; all out_* data = 0.
//  - Push when in_valid&in_ready; pop when out_valid&out_ready. Decode happens combinationally
//    at push; fields stored in FIFO. Latency: accepted at edge N -> out_valid at N+1 (empty FIFO).
//  - Simultaneous push+pop: count unchanged, both pointers advance; legal at any non-full count.
//    Full: in_ready=0 even if out_ready=1 (no out_ready->in_ready comb path).
//  - Pointers wrap modulo DEPTH. Outputs present FIFO head directly (no extra register stage).
//  - flush=1 at edge: count=0, pointers=0; concurrent push and pop ignored; flush dominates.
//  - Imm select by opcode: 0110111/0010111 U = {instr[31:12],12'b0} sign-ext to XLEN;
//    1101111 J; 1100111,0000011,0001111,1110011 I; 0100011 S; 1100011 B; 0110011/0111011 NONE(0);
//    0010011/0011011 I, except funct3 001/101 -> SHAMT: zero-ext instr[24:20] (XLEN=32) or
//    instr[25:20] (XLEN=64; 0011011 always 5-bit). I/S/B/J sign-extended from instr[31].
//  - Illegal: instr[1:0]!=2'b11, opcode outside above set, or XLEN=32 with 0011011/0111011;
//    illegal entries still buffered, imm_type=NONE, imm=0.
//  - Outputs are don't-care data-wise when out_valid=0 but must not be X after reset.
//  - Reset mid-operation drops all entries immediately, no completion.
// TESTING
//  1 addi x1,x0,-1 (0xFFF00093), XLEN=32 -> next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, type=I.
//  2 sw x1,12(x2) 0x00112623 -> imm=12,type=S; beq 0xFE000EE3 -> imm=0xFFFFFFFC,type=B;
//    jal x1,+2048 0x001000EF -> imm=0x800,type=J; lui 0x123450B7 -> imm=0x12345000,type=U.
//  3 slli x5,x5,3 0x00329293 -> type=SHAMT, imm=3; XLEN=64 slli x5,x5,33 0x02129293 -> imm=33.
//  4 0x00000000 and opcode 0x7F -> out_illegal=1, imm=0; XLEN=32 addiw 0x0010809B -> illegal=1.
//  5 DEPTH=2, out_ready=0: push 3 back-to-back -> in_ready=0 after 2nd; 3rd held; out_ready=1
//    one cycle -> 1 pop, in_ready=1 next cycle; pop order = push order (PCs 0x0,0x4,0x8).
//  6 Flush with 2 entries plus concurrent push -> next cycle out_valid=0, count=0; async rst
//    pulse mid-stream -> out_valid=0, in_ready=1 immediately, all data outputs 0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// RV32I/RV64I decode stage: splits instruction fields, selects the opcode's immediate and
// flags illegal encodings at push time, then buffers decoded entries in a DEPTH-entry FIFO.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    logic [6:0]      op;
    logic [2:0]      f3;
    logic            is_shift;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    assign op       = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Word-sized ops (OP-IMM-32 / OP-32) only exist in RV64.
    always_comb begin
        dec_type    = IMM_NONE;
        dec_illegal = 1'b0;
        case (op)
            7'b0110111, 7'b0010111:                         dec_type = IMM_U;
            7'b1101111:                                     dec_type = IMM_J;
            7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: dec_type = IMM_I;
            7'b0100011:                                     dec_type = IMM_S;
            7'b1100011:                                     dec_type = IMM_B;
            7'b0110011:                                     dec_type = IMM_NONE;
            7'b0111011:                                     dec_illegal = (XLEN == 32);
            7'b0010011:                                     dec_type = is_shift ? IMM_SHAMT : IMM_I;
            7'b0011011: begin
                if (XLEN == 32) dec_illegal = 1'b1;
                else            dec_type = is_shift ? IMM_SHAMT : IMM_I;
            end
            default:                                        dec_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;
        if (dec_illegal)            dec_type = IMM_NONE;
    end

    always_comb begin
        dec_imm = '0;
        case (dec_type)
            IMM_I: dec_imm = XLEN'($signed(in_instr[31:20]));
            IMM_S: dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            IMM_B: dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                            in_instr[11:8], 1'b0}));
            IMM_U: dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            IMM_J: dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                            in_instr[30:21], 1'b0}));
            IMM_SHAMT: begin
                if ((XLEN == 64) && (op == 7'b0010011)) dec_imm = XLEN'(in_instr[25:20]);
                else                                     dec_imm = XLEN'(in_instr[24:20]);
            end
            default: dec_imm = '0;
        endcase
    end

    // in_ready depends on registered count only, so a full FIFO never sees out_ready.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, imm: dec_imm,
                                 imm_type: dec_type, illegal: dec_illegal};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign out_pc       = mem[rd_ptr].pc;
    assign out_opcode   = mem[rd_ptr].instr[6:0];
    assign out_rd       = mem[rd_ptr].instr[11:7];
    assign out_rs1      = mem[rd_ptr].instr[19:15];
    assign out_rs2      = mem[rd_ptr].instr[24:20];
    assign out_funct3   = mem[rd_ptr].instr[14:12];
    assign out_funct7   = mem[rd_ptr].instr[31:25];
    assign out_imm      = mem[rd_ptr].imm;
    assign out_imm_type = mem[rd_ptr].imm_type;
    assign out_illegal  = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: an RV32/DEPTH=2 and an RV64/DEPTH=4 instance share stimulus
// and are each compared against a queue-based reference model with arithmetic immediate decode.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_op, a_f7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3, a_type;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_op, b_f7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3, b_type;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model entries are {pc[63:0], instr[31:0]}, oldest first.
    logic [95:0] qa[$];
    logic [95:0] qb[$];

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_opcode(a_op),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3), .out_funct7(a_f7),
        .out_imm(a_imm), .out_imm_type(a_type), .out_illegal(a_ill)
    );

    instr_decode_stage #(.XLEN(64), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_opcode(b_op),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3), .out_funct7(b_f7),
        .out_imm(b_imm), .out_imm_type(b_type), .out_illegal(b_ill)
    );

    // Immediate values are built as signed integer sums of their bit fields.
    function automatic void ref_decode(input logic [31:0] i, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] typ,
                                       output logic ill);
        longint     v;
        logic [6:0] op;
        v = 0; typ = 3'd0; ill = 1'b0; op = i[6:0];
        case (op)
            7'h37, 7'h17: begin
                typ = 3'd4;
                v = longint'(i[30:12]) * 4096 - (i[31] ? 64'sd2147483648 : 64'sd0);
            end
            7'h6F: begin
                typ = 3'd5;
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                  + longint'(i[30:21]) * 2 - (i[31] ? 64'sd1048576 : 64'sd0);
            end
            7'h67, 7'h03, 7'h0F, 7'h73: begin
                typ = 3'd1;
                v = longint'(i[30:20]) - (i[31] ? 64'sd2048 : 64'sd0);
            end
            7'h23: begin
                typ = 3'd2;
                v = longint'(i[30:25]) * 32 + longint'(i[11:7]) - (i[31] ? 64'sd2048 : 64'sd0);
            end
            7'h63: begin
                typ = 3'd3;
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                  - (i[31] ? 64'sd4096 : 64'sd0);
            end
            7'h33: typ = 3'd0;
            7'h3B: ill = (xlen == 32);
            7'h13, 7'h1B: begin
                if (op == 7'h1B && xlen == 32) ill = 1'b1;
                else if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    typ = 3'd6;
                    v = (xlen == 64 && op == 7'h13) ? longint'(i[25:20]) : longint'(i[24:20]);
                end else begin
                    typ = 3'd1;
                    v = longint'(i[30:20]) - (i[31] ? 64'sd2048 : 64'sd0);
                end
            end
            default: ill = 1'b1;
        endcase
        if (i[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin typ = 3'd0; v = 0; end
        imm = v;
    endfunction

    task automatic step();
        bit pa, pb, ra, rb;
        pa = in_valid && (qa.size() < 2);
        pb = in_valid && (qb.size() < 4);
        ra = out_ready && (qa.size() > 0);
        rb = out_ready && (qb.size() > 0);
        @(posedge clk);
        #1;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ra) void'(qa.pop_front());
            if (rb) void'(qb.pop_front());
            if (pa) qa.push_back({in_pc, in_instr});
            if (pb) qb.push_back({in_pc, in_instr});
        end
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got %b expected 0101",
                     {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
        end
        n_cmp++;
        if ({a_pc, a_imm, a_op, a_rd, a_type, a_ill, b_pc, b_imm, b_op, b_type, b_ill} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got a_pc=%h a_imm=%h b_pc=%h b_imm=%h expected all 0",
                     a_pc, a_imm, b_pc, b_imm);
        end
    endtask

    task automatic test_imm_types();
        logic [31:0] ti[6] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3,
                               32'h001000EF, 32'h123450B7, 32'h00329293};
        logic [63:0] te[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd12, 64'hFFFF_FFFF_FFFF_FFFC,
                               64'h800, 64'h12345000, 64'd3};
        logic [2:0]  tt[6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6};
        for (int k = 0; k < 6; k++) begin
            push_one(ti[k], 64'h100 + 64'(4 * k));
            n_cmp++;
            if ({a_out_valid, a_rd, a_imm, a_type} !== {1'b1, ti[k][11:7], te[k][31:0], tt[k]}) begin
                n_fail++;
                $display("[TB] FAIL imm32_%0d: got v=%b rd=%0d imm=%h type=%0d expected v=1 rd=%0d imm=%h type=%0d",
                         k, a_out_valid, a_rd, a_imm, a_type, ti[k][11:7], te[k][31:0], tt[k]);
            end
            n_cmp++;
            if ({b_imm, b_type} !== {te[k], tt[k]}) begin
                n_fail++;
                $display("[TB] FAIL imm64_%0d: got imm=%h type=%0d expected imm=%h type=%0d",
                         k, b_imm, b_type, te[k], tt[k]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_shamt_illegal();
        logic [31:0] il[2] = '{32'h00000000, 32'h0000007F};
        push_one(32'h02129293, 64'h200);
        n_cmp++;
        if ({b_imm, b_type, a_imm, a_type} !== {64'd33, 3'd6, 32'd1, 3'd6}) begin
            n_fail++;
            $display("[TB] FAIL shamt: got b_imm=%0d b_type=%0d a_imm=%0d a_type=%0d expected 33 6 1 6",
                     b_imm, b_type, a_imm, a_type);
        end
        drain();
        for (int k = 0; k < 2; k++) begin
            push_one(il[k], 64'h300);
            n_cmp++;
            if ({a_ill, a_imm, a_type, b_ill, b_imm, b_type} !== {1'b1, 32'd0, 3'd0, 1'b1, 64'd0, 3'd0}) begin
                n_fail++;
                $display("[TB] FAIL illegal_%0d: got a_ill=%b a_imm=%h b_ill=%b b_imm=%h expected 1 0 1 0",
                         k, a_ill, a_imm, b_ill, b_imm);
            end
            drain();
        end
        push_one(32'h0010809B, 64'h400);
        n_cmp++;
        if ({a_ill, a_imm, b_ill, b_imm, b_type} !== {1'b1, 32'd0, 1'b0, 64'd1, 3'd1}) begin
            n_fail++;
            $display("[TB] FAIL addiw: got a_ill=%b a_imm=%h b_ill=%b b_imm=%h b_type=%0d expected 1 0 0 1 1",
                     a_ill, a_imm, b_ill, b_imm, b_type);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        in_pc = 64'h0; step();
        in_pc = 64'h4; step();
        n_cmp++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL full_ready: got %b expected 0", a_in_ready);
        end
        in_pc = 64'h8; step();
        n_cmp++;
        if ({a_in_ready, a_pc} !== {1'b0, 32'h0}) begin
            n_fail++; $display("[TB] FAIL held: got ready=%b pc=%h expected 0 0", a_in_ready, a_pc);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp++;
        if ({a_in_ready, a_pc} !== {1'b1, 32'h4}) begin
            n_fail++; $display("[TB] FAIL after_pop: got ready=%b pc=%h expected 1 4", a_in_ready, a_pc);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if ({a_out_valid, a_pc} !== {1'b1, 32'h8}) begin
            n_fail++; $display("[TB] FAIL order: got v=%b pc=%h expected 1 8", a_out_valid, a_pc);
        end
        step();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL emptied: got %b expected 0", a_out_valid);
        end
        out_ready = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        push_one(32'h00100093, 64'h10);
        push_one(32'h00200093, 64'h14);
        in_valid = 1'b1; in_instr = 32'h00300093; in_pc = 64'h18;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
            n_fail++;
            $display("[TB] FAIL flush: got %b expected 0101",
                     {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
        end
    endtask

    task automatic test_async_reset();
        push_one(32'hFFF00093, 64'h20);
        push_one(32'h123450B7, 64'h24);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
            n_fail++;
            $display("[TB] FAIL async_rst_handshake: got %b expected 0101",
                     {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
        end
        n_cmp++;
        if ({a_pc, a_imm, a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_type, a_ill,
             b_pc, b_imm, b_op, b_type, b_ill} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_rst_data: got a_pc=%h a_imm=%h b_pc=%h b_imm=%h expected all 0",
                     a_pc, a_imm, b_pc, b_imm);
        end
        qa.delete();
        qb.delete();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [6:0]  ops[15] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h0F, 7'h73, 7'h23,
                                 7'h63, 7'h33, 7'h3B, 7'h13, 7'h1B, 7'h00, 7'h00};
        logic [95:0] h;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        for (int it = 0; it < 400; it++) begin
            n_cmp++;
            if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !==
                {qa.size() != 0, qa.size() < 2, qb.size() != 0, qb.size() < 4}) begin
                n_fail++;
                $display("[TB] FAIL rand_handshake it=%0d: got %b expected %b", it,
                         {a_out_valid, a_in_ready, b_out_valid, b_in_ready},
                         {qa.size() != 0, qa.size() < 2, qb.size() != 0, qb.size() < 4});
            end
            if (qa.size() > 0) begin
                h = qa[0];
                ref_decode(h[31:0], 32, imm, typ, ill);
                n_cmp++;
                if ({a_pc, a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, a_type, a_ill} !==
                    {h[63:32], h[6:0], h[11:7], h[19:15], h[24:20], h[14:12], h[31:25],
                     imm[31:0], typ, ill}) begin
                    n_fail++;
                    $display("[TB] FAIL rand32 it=%0d instr=%h: got pc=%h imm=%h type=%0d ill=%b expected pc=%h imm=%h type=%0d ill=%b",
                             it, h[31:0], a_pc, a_imm, a_type, a_ill, h[63:32], imm[31:0], typ, ill);
                end
            end
            if (qb.size() > 0) begin
                h = qb[0];
                ref_decode(h[31:0], 64, imm, typ, ill);
                n_cmp++;
                if ({b_pc, b_op, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm, b_type, b_ill} !==
                    {h[95:32], h[6:0], h[11:7], h[19:15], h[24:20], h[14:12], h[31:25],
                     imm, typ, ill}) begin
                    n_fail++;
                    $display("[TB] FAIL rand64 it=%0d instr=%h: got pc=%h imm=%h type=%0d ill=%b expected pc=%h imm=%h type=%0d ill=%b",
                             it, h[31:0], b_pc, b_imm, b_type, b_ill, h[95:32], imm, typ, ill);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (it < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = $urandom;
            if ($urandom_range(0, 14) < 13) in_instr[6:0] = ops[$urandom_range(0, 12)];
            in_pc     = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #13;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_imm_types();
        test_shamt_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
